instruction_decode_fsm: RTL and testbench

- Issuing side of the decode→execute handshake: fetches instructions from code ROM, reads two operand rows from data RAM, and presents a decoded instruction (operation, two 96-bit sources, destination) to the execution unit.
- Honours the execution unit's busy, latch-acknowledge, branch-taken and branch-not-taken signals.
- Tracks the instruction pointer, including redirects on taken branches.
- Sits between code ROM, data RAM read ports and the execution unit inside each core.

---
 rtl/instruction_decode_fsm_pkg.sv | 27 ++
 rtl/instruction_decode_fsm_operand_forward_latch.sv | 57 +++++
 rtl/instruction_decode_fsm.sv | 180 ++++++++++++++++++
 tb/tb_instruction_decode_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_fsm_pkg.sv
// rtl/instruction_decode_fsm_pkg.sv - decode FSM states, instruction field layout and opcode constants
package instruction_decode_fsm_pkg;

  localparam int DEF_OP_W   = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_ROM_W  = 16;
  localparam int DEF_ROW_W  = 96;

  localparam logic [DEF_OP_W-1:0] DEF_HALT_OP = 16'h0000;

  localparam logic [2:0] DEC_IDLE        = 3'd0;
  localparam logic [2:0] DEC_FETCH       = 3'd1;
  localparam logic [2:0] DEC_DECODE      = 3'd2;
  localparam logic [2:0] DEC_OPERAND     = 3'd3;
  localparam logic [2:0] DEC_ISSUE       = 3'd4;
  localparam logic [2:0] DEC_WAIT_BRANCH = 3'd5;

  // ROM word is {op,dest,src1,src0}; slots counted in ADDR_W units from the LSB
  localparam int FLD_SRC0 = 0;
  localparam int FLD_SRC1 = 1;
  localparam int FLD_DEST = 2;
  localparam int FLD_OP   = 3;

  // Branch class is flagged by the opcode MSB
  localparam int BRANCH_MSB_OFFSET = 1;

endpackage

// File: rtl/instruction_decode_fsm_operand_forward_latch.sv
// rtl/instruction_decode_fsm_operand_forward_latch.sv - one operand row register with optional write-back snoop
// Snoop path is built only when DECODE_DATA_FWD_EN is defined.
module instruction_decode_fsm_operand_forward_latch #(
  parameter int ADDR_W = 16,
  parameter int ROW_W  = 96
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_snoop,
  input  logic              i_issue,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ROW_W-1:0]  i_ram_value,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ROW_W-1:0]  i_wr_data,
  output logic [ROW_W-1:0]  o_row
);

  logic [ROW_W-1:0] r_row;

  assign o_row = r_row;

`ifdef DECODE_DATA_FWD_EN
  logic             r_fwd_flag;
  logic [ROW_W-1:0] r_fwd_row;
  logic             w_hit;

  assign w_hit = i_snoop && i_wr_en && (i_wr_addr == i_addr);

  // A write landing in the same cycle as the load is newer than both RAM data and the buffer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row      <= '0;
      r_fwd_flag <= 1'b0;
      r_fwd_row  <= '0;
    end else begin
      if (w_hit) r_fwd_row <= i_wr_data;
      if (i_clear) r_fwd_flag <= 1'b0;
      else if (w_hit) r_fwd_flag <= 1'b1;
      if (i_load) r_row <= w_hit ? i_wr_data : (r_fwd_flag ? r_fwd_row : i_ram_value);
      else if (i_issue && w_hit) r_row <= i_wr_data;
    end
  end
`else
  logic w_unused_snoop;

  assign w_unused_snoop = ^{i_snoop, i_issue, i_clear, i_addr, i_wr_en, i_wr_addr, i_wr_data};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_row <= '0;
    else if (i_load) r_row <= i_ram_value;
  end
`endif

endmodule

// File: rtl/instruction_decode_fsm.sv
// rtl/instruction_decode_fsm.sv - fetch/decode/issue FSM feeding the execution unit
// Optional DECODE_DATA_FWD_EN replaces the read-after-write stall with write-back snooping.
module instruction_decode_fsm
  import instruction_decode_fsm_pkg::*;
#(
  parameter int              OP_W    = DEF_OP_W,
  parameter int              ADDR_W  = DEF_ADDR_W,
  parameter int              ROM_W   = DEF_ROM_W,
  parameter int              ROW_W   = DEF_ROW_W,
  parameter logic [OP_W-1:0] HALT_OP = DEF_HALT_OP
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iEnable,
  input  logic [ROM_W-1:0]         iInitialIP,
  output logic [ROM_W-1:0]         oIP,
  input  logic [OP_W+3*ADDR_W-1:0] iInstruction,
  output logic [ADDR_W-1:0]        oRAMReadAddress0,
  output logic [ADDR_W-1:0]        oRAMReadAddress1,
  input  logic [ROW_W-1:0]         iRAMValue0,
  input  logic [ROW_W-1:0]         iRAMValue1,
  output logic                     oDecodeDone,
  output logic [OP_W-1:0]          oOperation,
  output logic [ROW_W-1:0]         oSource0,
  output logic [ROW_W-1:0]         oSource1,
  output logic [ADDR_W-1:0]        oDestination,
  input  logic                     iExeBusy,
  input  logic                     iExeLatchedValues,
  input  logic                     iJumpFlag,
  input  logic [ROM_W-1:0]         iJumpIp,
  input  logic                     iBranchNotTaken,
  input  logic [ADDR_W-1:0]        iLastDestination,
  input  logic                     iRAMWriteEnable,
  input  logic [ROW_W-1:0]         iRAMBus,
  output logic                     oDone,
  output logic                     oBusy
);

  logic [2:0]        r_state;
  logic [ROM_W-1:0]  r_ip;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] r_src0;
  logic [ADDR_W-1:0] r_src1;
  logic [OP_W-1:0]   r_operation;
  logic [ADDR_W-1:0] r_destination;

  logic [OP_W-1:0]   w_in_op;
  logic [ADDR_W-1:0] w_in_dest;
  logic [ADDR_W-1:0] w_in_src0;
  logic [ADDR_W-1:0] w_in_src1;
  logic [ADDR_W-1:0] w_src0;
  logic [ADDR_W-1:0] w_src1;
  logic              w_hazard;
  logic              w_issue;
  logic              w_is_halt;
  logic              w_is_branch;
  logic              w_snoop;

  assign w_in_op   = iInstruction[FLD_OP*ADDR_W +: OP_W];
  assign w_in_dest = iInstruction[FLD_DEST*ADDR_W +: ADDR_W];
  assign w_in_src1 = iInstruction[FLD_SRC1*ADDR_W +: ADDR_W];
  assign w_in_src0 = iInstruction[FLD_SRC0*ADDR_W +: ADDR_W];

  // ROM output is held while in DECODE, so the read addresses come straight from it
  assign w_src0 = (r_state == DEC_DECODE) ? w_in_src0 : r_src0;
  assign w_src1 = (r_state == DEC_DECODE) ? w_in_src1 : r_src1;

`ifdef DECODE_DATA_FWD_EN
  assign w_hazard = 1'b0;
`else
  assign w_hazard = iExeBusy && ((w_in_src0 == iLastDestination) || (w_in_src1 == iLastDestination));
`endif

  assign w_issue     = (r_state == DEC_ISSUE) && !iExeBusy;
  assign w_is_halt   = (r_op == HALT_OP);
  assign w_is_branch = r_op[OP_W-BRANCH_MSB_OFFSET];
  assign w_snoop     = (r_state == DEC_DECODE) || (r_state == DEC_OPERAND) || (r_state == DEC_ISSUE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= DEC_IDLE;
      r_ip          <= '0;
      r_op          <= '0;
      r_dest        <= '0;
      r_src0        <= '0;
      r_src1        <= '0;
      r_operation   <= '0;
      r_destination <= '0;
    end else begin
      case (r_state)
        DEC_IDLE: begin
          if (iEnable) begin
            r_ip    <= iInitialIP;
            r_state <= DEC_FETCH;
          end
        end
        DEC_FETCH: r_state <= DEC_DECODE;
        DEC_DECODE: begin
          r_op   <= w_in_op;
          r_dest <= w_in_dest;
          r_src0 <= w_in_src0;
          r_src1 <= w_in_src1;
          if (!w_hazard) r_state <= DEC_OPERAND;
        end
        DEC_OPERAND: begin
          r_operation   <= r_op;
          r_destination <= r_dest;
          r_state       <= DEC_ISSUE;
        end
        DEC_ISSUE: begin
          if (!iExeBusy) begin
            if (w_is_halt) begin
              r_state <= DEC_IDLE;
            end else if (w_is_branch) begin
              r_state <= DEC_WAIT_BRANCH;
            end else begin
              r_ip    <= r_ip + ROM_W'(1);
              r_state <= DEC_FETCH;
            end
          end
        end
        DEC_WAIT_BRANCH: begin
          if (iJumpFlag) begin
            r_ip    <= iJumpIp;
            r_state <= DEC_FETCH;
          end else if (iBranchNotTaken) begin
            r_ip    <= r_ip + ROM_W'(1);
            r_state <= DEC_FETCH;
          end
        end
        default: r_state <= DEC_IDLE;
      endcase
    end
  end

  instruction_decode_fsm_operand_forward_latch #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_src0_latch (
    .i_clk       (Clock),
    .i_rst       (Reset),
    .i_load      (r_state == DEC_OPERAND),
    .i_snoop     (w_snoop),
    .i_issue     (r_state == DEC_ISSUE),
    .i_clear     (w_issue),
    .i_addr      (w_src0),
    .i_ram_value (iRAMValue0),
    .i_wr_en     (iRAMWriteEnable),
    .i_wr_addr   (iLastDestination),
    .i_wr_data   (iRAMBus),
    .o_row       (oSource0)
  );

  instruction_decode_fsm_operand_forward_latch #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_src1_latch (
    .i_clk       (Clock),
    .i_rst       (Reset),
    .i_load      (r_state == DEC_OPERAND),
    .i_snoop     (w_snoop),
    .i_issue     (r_state == DEC_ISSUE),
    .i_clear     (w_issue),
    .i_addr      (w_src1),
    .i_ram_value (iRAMValue1),
    .i_wr_en     (iRAMWriteEnable),
    .i_wr_addr   (iLastDestination),
    .i_wr_data   (iRAMBus),
    .o_row       (oSource1)
  );

  assign oIP              = r_ip;
  assign oRAMReadAddress0 = w_src0;
  assign oRAMReadAddress1 = w_src1;
  assign oDecodeDone      = w_issue;
  assign oDone            = w_issue && w_is_halt;
  assign oBusy            = (r_state != DEC_IDLE);
  assign oOperation       = r_operation;
  assign oDestination     = r_destination;

`ifndef SYNTHESIS
  a_latch_handshake: assert property (@(posedge Clock) disable iff (Reset) iExeLatchedValues == oDecodeDone);
`endif

endmodule

// File: tb/tb_instruction_decode_fsm.sv
// tb/tb_instruction_decode_fsm.sv - scoreboard bench with sequential ISA reference model
module tb_instruction_decode_fsm;

  typedef struct {
    logic [15:0] op;
    logic [15:0] dest;
    logic [95:0] s0;
    logic [95:0] s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iEnable = 1'b0;
  logic [15:0] iInitialIP = '0;
  logic [15:0] oIP;
  logic [63:0] rom_q = '0;
  logic [15:0] rd_addr0, rd_addr1;
  logic [95:0] ram_q0 = '0, ram_q1 = '0;
  logic        dec_done;
  logic [15:0] oOperation;
  logic [95:0] oSource0, oSource1;
  logic [15:0] oDestination;
  logic        oDone, oBusy;

  logic        exe_busy = 1'b0, force_busy = 1'b0;
  logic        exe_we = 1'b0;
  logic [15:0] exe_ldest = 16'hFFFF;
  logic [95:0] exe_bus = '0;
  logic        exe_jump = 1'b0, exe_nt = 1'b0, man_jump = 1'b0;
  logic [15:0] exe_jip = '0;
  logic        hold_branch = 1'b0;
  int          lat_force = 0;

  logic [63:0] rom [0:255];
  logic [95:0] ram [0:255];
  logic [95:0] mram [0:255];
  exp_t        exp_q[$];
  int          br_dec_q[$];
  logic [15:0] br_ip_q[$];

  int n_checks = 0;
  int n_errors = 0;

  instruction_decode_fsm dut (
    .Clock             (clk),
    .Reset             (rst),
    .iEnable           (iEnable),
    .iInitialIP        (iInitialIP),
    .oIP               (oIP),
    .iInstruction      (rom_q),
    .oRAMReadAddress0  (rd_addr0),
    .oRAMReadAddress1  (rd_addr1),
    .iRAMValue0        (ram_q0),
    .iRAMValue1        (ram_q1),
    .oDecodeDone       (dec_done),
    .oOperation        (oOperation),
    .oSource0          (oSource0),
    .oSource1          (oSource1),
    .oDestination      (oDestination),
    .iExeBusy          (exe_busy | force_busy),
    .iExeLatchedValues (dec_done),
    .iJumpFlag         (exe_jump | man_jump),
    .iJumpIp           (man_jump ? 16'd40 : exe_jip),
    .iBranchNotTaken   (exe_nt),
    .iLastDestination  (exe_ldest),
    .iRAMWriteEnable   (exe_we),
    .iRAMBus           (exe_bus),
    .oDone             (oDone),
    .oBusy             (oBusy)
  );

  // Synchronous ROM and read-before-write data RAM
  always @(posedge clk) begin
    rom_q  <= rom[oIP[7:0]];
    ram_q0 <= ram[rd_addr0[7:0]];
    ram_q1 <= ram[rd_addr1[7:0]];
    if (exe_we) ram[exe_ldest[7:0]] <= exe_bus;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: execute the program sequentially; ALU ops write src0+src1 to dest
  task automatic model_run(input logic [15:0] start, input int forced);
    logic [15:0] ip;
    logic [63:0] w;
    exp_t        e;
    int          d;
    for (int i = 0; i < 256; i++) mram[i] = ram[i];
    ip = start;
    for (int n = 0; n < 300; n++) begin
      w = rom[ip[7:0]];
      e.op = w[63:48]; e.dest = w[47:32];
      e.s0 = mram[w[7:0]]; e.s1 = mram[w[23:16]];
      exp_q.push_back(e);
      if (e.op == 16'h0000) break;
      if (e.op[15]) begin
        d = (forced >= 0) ? forced : int'($urandom_range(0, 2));
        br_dec_q.push_back(d);
        ip = (d == 1) ? ip + 16'd1 : e.dest;
        br_ip_q.push_back(ip);
      end else begin
        mram[e.dest[7:0]] = e.s0 + e.s1;
        ip = ip + 16'd1;
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic gen_prog(input int n);
    clear_rom();
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        rom[i] = {16'h8000 | 16'($urandom_range(0, 127)), 16'($urandom_range(i + 1, n)), 32'h0};
      else
        rom[i] = {16'($urandom_range(1, 32767)), 16'($urandom_range(0, 15)),
                  16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))};
    end
  endtask

  task automatic start_prog(input logic [15:0] ip);
    @(posedge clk); #1;
    iEnable = 1'b1; iInitialIP = ip;
    @(posedge clk); #1;
    iEnable = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (oDone) begin got = 1; break; end
    end
    chk("program_terminates", got, 1'b1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: compare every issued instruction with the next expected one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && dec_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue_op", oOperation, 16'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_op", oOperation, e.op);
          chk("issue_dest", oDestination, e.dest);
          chk("issue_src0", oSource0, e.s0);
          chk("issue_src1", oSource1, e.s1);
          chk("issue_done_flag", oDone, e.op == 16'h0000);
        end
      end else if (oDone) begin
        chk("done_without_issue", oDone, 1'b0);
      end
    end
  end

  // Execution unit model: write-back after a latency, branch resolution after 1..3 cycles
  initial begin
    int          busy_cnt = 0, br_cnt = 0, br_d = 0, chk_stage = 0;
    logic [15:0] x_op = '0, x_dest = '0, br_exp = '0;
    logic [95:0] x_res = '0;
    forever begin
      @(negedge clk);
      if (chk_stage == 2) begin
        chk("branch_next_ip", oIP, br_exp);
        chk_stage = 0;
      end else if (chk_stage == 1) begin
        chk_stage = 2;
      end
      if (rst) begin
        busy_cnt = 0; br_cnt = 0; chk_stage = 0;
      end else if (dec_done) begin
        x_op = oOperation; x_dest = oDestination; x_res = oSource0 + oSource1;
        if (x_op[15]) begin
          if (!hold_branch) begin
            br_cnt = $urandom_range(1, 3);
            if (br_dec_q.size() > 0) begin
              br_d = br_dec_q.pop_front(); br_exp = br_ip_q.pop_front();
            end else begin
              chk("branch_expected", 1'b1, 1'b0);
              br_d = 1; br_exp = '0;
            end
          end
        end else if (x_op != 16'h0000) begin
          busy_cnt = (lat_force != 0) ? lat_force : int'($urandom_range(1, 5));
        end
      end
      @(posedge clk); #1;
      exe_busy = 1'b0; exe_we = 1'b0; exe_ldest = 16'hFFFF; exe_jump = 1'b0; exe_nt = 1'b0;
      if (busy_cnt > 0) begin
        exe_busy = 1'b1; exe_ldest = x_dest;
        if (busy_cnt == 1) begin exe_we = 1'b1; exe_bus = x_res; end
        busy_cnt--;
      end
      if (br_cnt > 0) begin
        br_cnt--;
        if (br_cnt == 0) begin
          exe_jump = (br_d != 1); exe_nt = (br_d != 0); exe_jip = x_dest; chk_stage = 1;
        end
      end
    end
  end

  initial begin
    int   n;
    exp_t e;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    clear_rom();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ip", oIP, 16'h0);
    chk("rst_decode_done", dec_done, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_src0", oSource0, 96'h0);
    chk("rst_op", oOperation, 16'h0);
    chk("rst_rd_addr0", rd_addr0, 16'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Start at IP 5, first issue 3 cycles after FETCH
    ram[16'h20] = 96'hABCD_0000_1111_2222_3333; ram[16'h21] = 96'h5;
    rom[5] = {16'h0011, 16'h0030, 16'h0021, 16'h0020};
    model_run(16'd5, -1);
    start_prog(16'd5);
    @(negedge clk);
    chk("start_ip", oIP, 16'd5);
    chk("start_busy", oBusy, 1'b1);
    n = 0;
    while (!dec_done && n < 10) begin @(negedge clk); n++; end
    chk("issue_latency", n, 3);
    wait_done();
    settle();

    // Busy held for 4 cycles in ISSUE
    clear_rom();
    rom[0] = {16'h0012, 16'h0007, 16'h0002, 16'h0001};
    model_run(16'd0, -1);
    force_busy = 1'b1;
    start_prog(16'd0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("held_by_busy", dec_done, 1'b0);
    end
    @(posedge clk); #1; force_busy = 1'b0;
    @(negedge clk); chk("pulse_when_free", dec_done, 1'b1);
    @(negedge clk); chk("pulse_width", dec_done, 1'b0);
    wait_done();
    settle();

    // Branch at 10: taken, not taken, both
    for (int d = 0; d < 3; d++) begin
      clear_rom();
      rom[10] = {16'h8001, 16'd40, 32'h0};
      rom[11] = {16'h0003, 16'h0009, 16'h0001, 16'h0002};
      rom[40] = {16'h0002, 16'h0008, 16'h0003, 16'h0004};
      model_run(16'd10, d);
      start_prog(16'd10);
      wait_done();
      settle();
    end

    // Read-after-write hazard on 0x20, write-back finishing late
    clear_rom();
    ram[1] = 96'h100; ram[2] = 96'h23; ram[3] = 96'h7;
    rom[0] = {16'h0004, 16'h0020, 16'h0002, 16'h0001};
    rom[1] = {16'h0005, 16'h0031, 16'h0003, 16'h0020};
    model_run(16'd0, -1);
    chk("hazard_model_value", mram[16'h31], 96'h12A);
    lat_force = 4;
    start_prog(16'd0);
    wait_done();
    settle();
    lat_force = 0;

    // HALT at IP 3
    clear_rom();
    model_run(16'd3, -1);
    start_prog(16'd3);
    wait_done();
    @(negedge clk);
    chk("halt_busy_drops", oBusy, 1'b0);
    chk("halt_ip_holds", oIP, 16'd3);
    chk("halt_done_single", oDone, 1'b0);
    settle();

    // Reset while waiting for branch resolution
    clear_rom();
    rom[0] = {16'h8001, 16'd40, 32'h0};
    e.op = 16'h8001; e.dest = 16'd40; e.s0 = ram[0]; e.s1 = ram[0];
    exp_q.push_back(e);
    hold_branch = 1'b1;
    start_prog(16'd0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ip", oIP, 16'h0);
    chk("async_rst_busy", oBusy, 1'b0);
    chk("async_rst_op", oOperation, 16'h0);
    chk("async_rst_dest", oDestination, 16'h0);
    chk("async_rst_src0", oSource0, 96'h0);
    @(posedge clk); #1; rst = 1'b0; man_jump = 1'b1;
    @(posedge clk); #1; man_jump = 1'b0;
    @(negedge clk);
    chk("jump_after_rst_busy", oBusy, 1'b0);
    chk("jump_after_rst_ip", oIP, 16'h0);
    hold_branch = 1'b0;
    settle();

    // Randomized programs
    for (int p = 0; p < 8; p++) begin
      gen_prog($urandom_range(4, 14));
      model_run(16'd0, -1);
      start_prog(16'd0);
      wait_done();
      settle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
